slt_cmp_sched: RTL and testbench
================================

SLT_CMP_SCHED -- requirements
Module: slt_cmp_sched

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 4, meaning subtractor slice width per beat; legal values 4 and 8; BEATS = 32/SLICE_W.
REQ-002 The block SHALL have port I_CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port I_RST_N, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port I_REQ0_VALID, input, 1, requester 0 has a compare pending.
REQ-005 The block SHALL have port O_REQ0_READY, output, 1, requester 0 accepted this cycle when VALID also high.
REQ-006 The block SHALL have ports I_REQ0_OP_A and I_REQ0_OP_B, input, 32 each, requester 0 operands.
REQ-007 The block SHALL have port I_REQ0_U, input, 1, requester 0 mode: 1 = SLTU, 0 = SLT.
REQ-008 The block SHALL have ports I_REQ1_VALID, O_REQ1_READY, I_REQ1_OP_A, I_REQ1_OP_B and I_REQ1_U, identical to REQ-004..007 for requester 1.
REQ-009 The block SHALL have port O_RSP_VALID, output, 1, result available.
REQ-010 The block SHALL have port I_RSP_READY, input, 1, consumer takes the result.
REQ-011 The block SHALL have port O_RSP_RESULT, output, 1, the result: 1 if A < B under the latched mode.
REQ-012 The block SHALL have port O_RSP_ID, output, 1, index of the requester that owns the result.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE: READY SHALL be asserted combinationally only to the granted requester, and only when that requester's VALID is high.
REQ-015 On acceptance (VALID&READY) the block SHALL latch A, B, U and ID, clear the borrow register and beat counter, and go to RUN.
REQ-016 RUN: each cycle SHALL compute one SLICE_W slice, LSB slice first, as A - B - borrow, updating the borrow register and incrementing the counter.
REQ-017 After beat BEATS-1 the FSM SHALL go to DONE; RUN lasts exactly BEATS cycles.
REQ-018 DONE: O_RSP_VALID SHALL be 1; O_RSP_RESULT and O_RSP_ID SHALL be registered and held stable until I_RSP_READY is high.
REQ-019 O_RSP_VALID SHALL rise BEATS+1 cycles after the acceptance edge (9 for SLICE_W=4).
REQ-020 If U=1, the result SHALL be the final borrow.
REQ-021 If U=0, the result SHALL be A[31] when A[31]^B[31]=1, and the final borrow otherwise.
REQ-022 On a DONE cycle with I_RSP_READY high, the FSM SHALL return to IDLE.
REQ-023 Acceptance SHALL NOT occur in that same DONE cycle; sustained throughput is one compare per BEATS+2 cycles.
REQ-024 Both READY outputs SHALL be 0 in RUN and DONE; operand changes there SHALL have no effect.
REQ-025 Default arbitration SHALL be fixed priority: REQ0 wins when both VALID are high.
REQ-026 Equal operands SHALL yield result 0 in both modes.

Reset
REQ-027 While I_RST_N is low, the FSM SHALL be IDLE, and counter, borrow, last-grant register, O_RSP_VALID, O_RSP_RESULT and O_RSP_ID SHALL be 0, independent of I_CLK.
REQ-028 A reset asserted during RUN or DONE SHALL discard the in-flight compare without producing a response.

Configuration
REQ-029 With macro CMP_RR_ARB_EN defined, arbitration SHALL be round-robin: when both are VALID, the requester not granted last wins; the last-grant register resets to 1 so REQ0 wins first; a lone VALID always wins.
REQ-030 Without CMP_RR_ARB_EN, the last-grant register SHALL be absent and REQ-025 SHALL apply.

Verification
REQ-031 REQ0 A=5, B=7, U=0 -> RESULT=1, ID=0, O_RSP_VALID 9 cycles after accept (SLICE_W=4); with SLICE_W=8 -> 5 cycles.
REQ-032 A=0xFFFFFFFF, B=0x00000001: U=0 -> 1; U=1 -> 0. A=0x80000000, B=0x7FFFFFFF, U=0 -> 1; A=B=0x00001234 -> 0.
REQ-033 Both requesters VALID continuously, I_RSP_READY=1 -> IDs 0,0,0 without macro; IDs 0,1,0,1 with CMP_RR_ARB_EN.
REQ-034 I_RSP_READY held low 5 cycles in DONE -> VALID, RESULT and ID stable; both READY stay 0; on release -> IDLE next cycle.
REQ-035 I_RST_N pulsed low at RUN beat 3 -> outputs 0 immediately, no response; next request A=2, B=1, U=1 -> result 0 at normal latency.

Source files
------------

// File: rtl/slt_cmp_sched.sv
// Two-requester serial SLT/SLTU comparator: one SLICE_W-bit borrow slice per cycle, LSB first.
// Optional round-robin arbitration when CMP_RR_ARB_EN is defined (fixed priority, REQ0 first, otherwise).
module slt_cmp_sched #(
  parameter int unsigned SLICE_W = 4
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_REQ0_VALID,
  output logic        O_REQ0_READY,
  input  logic [31:0] I_REQ0_OP_A,
  input  logic [31:0] I_REQ0_OP_B,
  input  logic        I_REQ0_U,
  input  logic        I_REQ1_VALID,
  output logic        O_REQ1_READY,
  input  logic [31:0] I_REQ1_OP_A,
  input  logic [31:0] I_REQ1_OP_B,
  input  logic        I_REQ1_U,
  output logic        O_RSP_VALID,
  input  logic        I_RSP_READY,
  output logic        O_RSP_RESULT,
  output logic        O_RSP_ID
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEATS  = DATA_W / SLICE_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               u_q, u_d;
  logic               id_q, id_d;
  logic               a_sign_q, a_sign_d;
  logic               sign_diff_q, sign_diff_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_result_q, rsp_result_d;
  logic               rsp_id_q, rsp_id_d;

  logic               grant_c;
  logic               ready0_c;
  logic               ready1_c;
  logic               accept_c;
  logic [SLICE_W:0]   a_slice_c;
  logic [SLICE_W:0]   b_slice_c;
  logic               borrow_nx_c;
  logic               last_beat_c;

`ifdef CMP_RR_ARB_EN
  // Round-robin: on contention the requester not granted last time wins.
  logic last_grant_q;

  always_comb begin
    grant_c = 1'b0;
    if (I_REQ0_VALID && I_REQ1_VALID) begin
      grant_c = ~last_grant_q;
    end else if (I_REQ1_VALID) begin
      grant_c = 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      last_grant_q <= 1'b1;
    end else if (accept_c) begin
      last_grant_q <= grant_c;
    end
  end
`else
  // Fixed priority: REQ1 is granted only when REQ0 is idle.
  always_comb begin
    grant_c = 1'b0;
    if (!I_REQ0_VALID && I_REQ1_VALID) begin
      grant_c = 1'b1;
    end
  end
`endif

  assign ready0_c     = (state_q == ST_IDLE) && I_REQ0_VALID && !grant_c;
  assign ready1_c     = (state_q == ST_IDLE) && I_REQ1_VALID && grant_c;
  assign accept_c     = ready0_c || ready1_c;
  assign O_REQ0_READY = ready0_c;
  assign O_REQ1_READY = ready1_c;

  // Borrow-out of (A_slice - B_slice - borrow_in): set when A_slice < B_slice + borrow_in.
  assign a_slice_c   = {1'b0, a_q[SLICE_W-1:0]};
  assign b_slice_c   = {1'b0, b_q[SLICE_W-1:0]} + (SLICE_W+1)'(borrow_q);
  assign borrow_nx_c = (a_slice_c < b_slice_c);
  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    u_d          = u_q;
    id_d         = id_q;
    a_sign_d     = a_sign_q;
    sign_diff_d  = sign_diff_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          a_d         = grant_c ? I_REQ1_OP_A : I_REQ0_OP_A;
          b_d         = grant_c ? I_REQ1_OP_B : I_REQ0_OP_B;
          u_d         = grant_c ? I_REQ1_U    : I_REQ0_U;
          id_d        = grant_c;
          a_sign_d    = a_d[DATA_W-1];
          sign_diff_d = a_d[DATA_W-1] ^ b_d[DATA_W-1];
          borrow_d    = 1'b0;
          cnt_d       = '0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        // Operands shift right so the current slice always sits in the LSBs.
        a_d      = a_q >> SLICE_W;
        b_d      = b_q >> SLICE_W;
        borrow_d = borrow_nx_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_beat_c) begin
          state_d      = ST_DONE;
          rsp_valid_d  = 1'b1;
          rsp_result_d = (!u_q && sign_diff_q) ? a_sign_q : borrow_nx_c;
          rsp_id_d     = id_q;
        end
      end

      ST_DONE: begin
        if (I_RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      u_q          <= 1'b0;
      id_q         <= 1'b0;
      a_sign_q     <= 1'b0;
      sign_diff_q  <= 1'b0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      u_q          <= u_d;
      id_q         <= id_d;
      a_sign_q     <= a_sign_d;
      sign_diff_q  <= sign_diff_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign O_RSP_VALID  = rsp_valid_q;
  assign O_RSP_RESULT = rsp_result_q;
  assign O_RSP_ID     = rsp_id_q;

endmodule

// File: tb/tb_slt_cmp_sched.sv
// Self-checking bench for slt_cmp_sched: vector table, scoreboard monitor and multi-cycle corner sequences.
module tb_slt_cmp_sched;

  localparam int unsigned SLICE_W = 4;
  localparam int unsigned BEATS   = 32 / SLICE_W;
  localparam int NVEC = 14;

  logic        I_CLK;
  logic        I_RST_N;
  logic        I_REQ0_VALID;
  logic        O_REQ0_READY;
  logic [31:0] I_REQ0_OP_A;
  logic [31:0] I_REQ0_OP_B;
  logic        I_REQ0_U;
  logic        I_REQ1_VALID;
  logic        O_REQ1_READY;
  logic [31:0] I_REQ1_OP_A;
  logic [31:0] I_REQ1_OP_B;
  logic        I_REQ1_U;
  logic        O_RSP_VALID;
  logic        I_RSP_READY;
  logic        O_RSP_RESULT;
  logic        O_RSP_ID;

  slt_cmp_sched #(.SLICE_W(SLICE_W)) dut (
    .I_CLK        (I_CLK),
    .I_RST_N      (I_RST_N),
    .I_REQ0_VALID (I_REQ0_VALID),
    .O_REQ0_READY (O_REQ0_READY),
    .I_REQ0_OP_A  (I_REQ0_OP_A),
    .I_REQ0_OP_B  (I_REQ0_OP_B),
    .I_REQ0_U     (I_REQ0_U),
    .I_REQ1_VALID (I_REQ1_VALID),
    .O_REQ1_READY (O_REQ1_READY),
    .I_REQ1_OP_A  (I_REQ1_OP_A),
    .I_REQ1_OP_B  (I_REQ1_OP_B),
    .I_REQ1_U     (I_REQ1_U),
    .O_RSP_VALID  (O_RSP_VALID),
    .I_RSP_READY  (I_RSP_READY),
    .O_RSP_RESULT (O_RSP_RESULT),
    .O_RSP_ID     (O_RSP_ID)
  );

  typedef struct {
    bit          req;
    logic [31:0] a;
    logic [31:0] b;
    bit          u;
    bit          exp;
  } vec_t;

  typedef struct {
    bit res;
    bit id;
    int acc_cyc;
  } sb_t;

  vec_t vecs [NVEC];
  sb_t  sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   rsp_seen = 0;

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit model(input logic [31:0] a, input logic [31:0] b, input bit u);
    if (u) return (a < b);
    return ($signed(a) < $signed(b));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: checks latency on first VALID, pops and compares on consumption.
  always @(negedge I_CLK) begin
    if (!I_RST_N) begin
      rsp_seen = 0;
    end else begin
      if (O_RSP_VALID && !rsp_seen) begin
        rsp_seen = 1;
        if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else                chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(BEATS + 1));
      end
      if (O_RSP_VALID && I_RSP_READY) begin
        rsp_seen = 0;
        if (sb.size() > 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("rsp_result", 32'(O_RSP_RESULT), 32'(e.res));
          chk("rsp_id", 32'(O_RSP_ID), 32'(e.id));
        end
      end
    end
  end

  task automatic drive_req(input bit req, input logic [31:0] a, input logic [31:0] b,
                           input bit u, input bit exp);
    bit got;
    @(posedge I_CLK); #1;
    if (req == 1'b0) begin
      I_REQ0_VALID = 1'b1; I_REQ0_OP_A = a; I_REQ0_OP_B = b; I_REQ0_U = u;
    end else begin
      I_REQ1_VALID = 1'b1; I_REQ1_OP_A = a; I_REQ1_OP_B = b; I_REQ1_U = u;
    end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge I_CLK);
      if ((req == 1'b0 && O_REQ0_READY) || (req == 1'b1 && O_REQ1_READY)) got = 1;
    end
    chk("handshake", 32'(got), 32'd1);
    if (got) sb.push_back('{exp, req, cyc});
    @(posedge I_CLK); #1;
    I_REQ0_VALID = 1'b0;
    I_REQ1_VALID = 1'b0;
    // Operands change while the compare runs; they must be ignored.
    I_REQ0_OP_A = ~a; I_REQ0_OP_B = ~b; I_REQ0_U = ~u;
    I_REQ1_OP_A = b;  I_REQ1_OP_B = a;  I_REQ1_U = ~u;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge I_CLK);
      if (sb.size() == 0 && !O_RSP_VALID) done = 1;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  initial begin
    bit   exp_ids [4];
    bit   acc_ids [4];
    int   acc_cyc [4];
    int   n;
    bit   spurious;
    logic [31:0] ra, rb;
    bit   ru, rq;

    vecs[0]  = '{1'b0, 32'd5,        32'd7,        1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'h00001234, 32'h00001234, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h00001234, 32'h00001234, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'd7,        32'd5,        1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'd1,        32'd2,        1'b1, 1'b1};
    vecs[8]  = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h00000010, 32'h0000000F, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h0000000F, 32'h00000010, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};

    I_RST_N = 1'b0;
    I_REQ0_VALID = 1'b0; I_REQ0_OP_A = '0; I_REQ0_OP_B = '0; I_REQ0_U = 1'b0;
    I_REQ1_VALID = 1'b0; I_REQ1_OP_A = '0; I_REQ1_OP_B = '0; I_REQ1_U = 1'b0;
    I_RSP_READY = 1'b1;

    repeat (3) @(negedge I_CLK);
    chk("reset_rsp_valid", 32'(O_RSP_VALID), 32'd0);
    chk("reset_rsp_result", 32'(O_RSP_RESULT), 32'd0);
    chk("reset_rsp_id", 32'(O_RSP_ID), 32'd0);
    chk("reset_ready0", 32'(O_REQ0_READY), 32'd0);
    chk("reset_ready1", 32'(O_REQ1_READY), 32'd0);
    I_RST_N = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive_req(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].exp);
      drain();
    end

    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; ru = 1'($urandom_range(0, 1)); rq = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ra ^ 32'h0000_0100;
      drive_req(rq, ra, rb, ru, model(ra, rb, ru));
      drain();
    end

    // Contention: both requesters valid continuously, consumer always ready.
    @(posedge I_CLK); #1;
    I_REQ0_VALID = 1'b1; I_REQ0_OP_A = 32'd1; I_REQ0_OP_B = 32'd2; I_REQ0_U = 1'b1;
    I_REQ1_VALID = 1'b1; I_REQ1_OP_A = 32'd3; I_REQ1_OP_B = 32'd2; I_REQ1_U = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge I_CLK);
      if (O_REQ0_READY) begin
        sb.push_back('{model(32'd1, 32'd2, 1'b1), 1'b0, cyc});
        acc_ids[n] = 1'b0; acc_cyc[n] = cyc; n++;
      end else if (O_REQ1_READY) begin
        sb.push_back('{model(32'd3, 32'd2, 1'b1), 1'b1, cyc});
        acc_ids[n] = 1'b1; acc_cyc[n] = cyc; n++;
      end
    end
    @(posedge I_CLK); #1;
    I_REQ0_VALID = 1'b0; I_REQ1_VALID = 1'b0;
    chk("contention_accepts", 32'(n), 32'd4);
`ifdef CMP_RR_ARB_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    if (n == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("arb_id%0d", k), 32'(acc_ids[k]), 32'(exp_ids[k]));
      for (int k = 0; k < 3; k++) chk($sformatf("throughput%0d", k), 32'(acc_cyc[k+1] - acc_cyc[k]), 32'(BEATS + 2));
    end
    drain();

    // Back-pressure: response held in DONE while the consumer stalls.
    I_RSP_READY = 1'b0;
    drive_req(1'b1, 32'd3, 32'd9, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 30 && !O_RSP_VALID; i++) @(negedge I_CLK);
    chk("stall_valid_seen", 32'(O_RSP_VALID), 32'd1);
    @(posedge I_CLK); #1;
    I_REQ0_VALID = 1'b1; I_REQ0_OP_A = 32'd4; I_REQ0_OP_B = 32'd4; I_REQ0_U = 1'b0;
    I_REQ1_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge I_CLK);
      chk("stall_valid", 32'(O_RSP_VALID), 32'd1);
      chk("stall_result", 32'(O_RSP_RESULT), 32'd1);
      chk("stall_id", 32'(O_RSP_ID), 32'd1);
      chk("stall_ready0", 32'(O_REQ0_READY), 32'd0);
      chk("stall_ready1", 32'(O_REQ1_READY), 32'd0);
    end
    @(posedge I_CLK); #1;
    I_RSP_READY = 1'b1;
    I_REQ1_VALID = 1'b0;
    @(negedge I_CLK);
    chk("release_no_accept", 32'(O_REQ0_READY), 32'd0);
    @(negedge I_CLK);
    chk("release_idle_valid", 32'(O_RSP_VALID), 32'd0);
    chk("release_idle_ready0", 32'(O_REQ0_READY), 32'd1);
    if (O_REQ0_READY) sb.push_back('{1'b0, 1'b0, cyc});
    @(posedge I_CLK); #1;
    I_REQ0_VALID = 1'b0;
    drain();

    // Leave RESULT=1, ID=1 registered so the reset clear below is observable.
    drive_req(1'b1, 32'd1, 32'd2, 1'b1, 1'b1);
    drain();

    // Reset mid-RUN discards the in-flight compare.
    drive_req(1'b0, 32'd1, 32'd2, 1'b1, 1'b1);
    repeat (3) @(posedge I_CLK);
    #1;
    I_RST_N = 1'b0;
    sb.delete();
    #1;
    chk("midrun_rst_valid", 32'(O_RSP_VALID), 32'd0);
    chk("midrun_rst_result", 32'(O_RSP_RESULT), 32'd0);
    chk("midrun_rst_id", 32'(O_RSP_ID), 32'd0);
    repeat (2) @(negedge I_CLK);
    #1;
    I_RST_N = 1'b1;
    spurious = 0;
    for (int i = 0; i < BEATS + 6; i++) begin
      @(negedge I_CLK);
      if (O_RSP_VALID) spurious = 1;
    end
    chk("no_rsp_after_reset", 32'(spurious), 32'd0);
    drive_req(1'b0, 32'd2, 32'd1, 1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
